vend_payout_driver: RTL and testbench

// - Downstream of the vending controller. Turns its product/change pulses into

---
 rtl/vend_payout_driver_if.sv | 25 ++
 rtl/vend_payout_driver.sv | 191 +++++++++++++++++++
 tb/tb_vend_payout_driver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vend_payout_driver_if.sv
// Handshake bundle between the vending controller side and the payout driver.
// The master drives requests and sensor levels; the slave drives actuators and status.
interface vend_payout_driver_if;
  logic       product;
  logic [1:0] change;
  logic       vend_done;
  logic       coin_sensed;
  logic       clear_fault;
  logic       vend_motor;
  logic       coin_eject;
  logic       busy;
  logic       fault;
  logic       payout_done;
  logic       overflow;

  modport master (
    output product, change, vend_done, coin_sensed, clear_fault,
    input  vend_motor, coin_eject, busy, fault, payout_done, overflow
  );

  modport slave (
    input  product, change, vend_done, coin_sensed, clear_fault,
    output vend_motor, coin_eject, busy, fault, payout_done, overflow
  );
endinterface

// File: rtl/vend_payout_driver.sv
// Payout sequencer: runs the product motor, then one timed hopper eject per coin of
// change, buffering one request and latching a sticky fault on actuator stall.
module vend_payout_driver #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  reset_n,
  vend_payout_driver_if.slave  bus
);
  localparam int MAX_A   = (TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX    = {TW{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VEND  = 3'd1;
  localparam logic [2:0] S_COIN  = 3'd2;
  localparam logic [2:0] S_SENSE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] r_coin_tmr;
  logic [1:0]    r_coins_left;
  logic [1:0]    w_coins_nxt;
  logic          r_pend_vld;
  logic [1:0]    r_pend_chg;
  logic          w_pend_vld_nxt;
  logic [1:0]    w_pend_chg_nxt;
  logic          r_sensed;
  logic          w_load;
  logic          w_ovf;
  logic          w_entry;
  logic          w_coin_entry;

  logic r_vend_motor;
  logic r_coin_eject;
  logic r_busy;
  logic r_fault;
  logic r_payout_done;
  logic r_overflow;

  assign w_entry      = (w_state_nxt != r_state);
  assign w_coin_entry = (w_state_nxt == S_COIN) && (r_state != S_COIN);

  // Next-state and coin bookkeeping for the payout sequence
  always_comb begin
    w_state_nxt = r_state;
    w_coins_nxt = r_coins_left;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_vld) begin
          w_load      = 1'b1;
          w_coins_nxt = r_pend_chg;
          w_state_nxt = S_VEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_VEND: begin
        if (bus.vend_done) begin
          w_state_nxt = (r_coins_left != 2'd0) ? S_COIN : S_DONE;
        end else if (r_timer >= TMO_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_state_nxt = S_VEND;
        end
      end
      S_COIN: begin
        if (r_timer >= PULSE_LAST) begin
          w_state_nxt = S_SENSE;
        end else begin
          w_state_nxt = S_COIN;
        end
      end
      S_SENSE: begin
        // a sense seen while the solenoid was still driven counts for this coin
        if (r_sensed || bus.coin_sensed) begin
          w_coins_nxt = (r_coins_left != 2'd0) ? (r_coins_left - 2'd1) : 2'd0;
          w_state_nxt = S_GAP;
        end else if (r_coin_tmr >= TMO_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_state_nxt = S_SENSE;
        end
      end
      S_GAP: begin
        if (r_timer >= GAP_LAST) begin
          w_state_nxt = (r_coins_left != 2'd0) ? S_COIN : S_DONE;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (bus.clear_fault) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Single-entry request buffer; a slot being loaded this cycle may be refilled
  always_comb begin
    w_pend_vld_nxt = r_pend_vld && !w_load;
    w_pend_chg_nxt = r_pend_chg;
    w_ovf          = 1'b0;
    if (bus.product) begin
      if (!r_pend_vld || w_load) begin
        w_pend_vld_nxt = 1'b1;
        w_pend_chg_nxt = bus.change;
      end else begin
        w_ovf = 1'b1;
      end
    end else begin
      w_ovf = 1'b0;
    end
  end

  // State, timers, buffer and sense latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= {TW{1'b0}};
      r_coin_tmr   <= {TW{1'b0}};
      r_coins_left <= 2'd0;
      r_pend_vld   <= 1'b0;
      r_pend_chg   <= 2'd0;
      r_sensed     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_coins_left <= w_coins_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_pend_chg   <= w_pend_chg_nxt;
      r_timer      <= w_entry ? {TW{1'b0}} :
                      ((r_timer == TMR_MAX) ? r_timer : r_timer + TW'(1));
      r_coin_tmr   <= w_coin_entry ? {TW{1'b0}} :
                      ((r_coin_tmr == TMR_MAX) ? r_coin_tmr : r_coin_tmr + TW'(1));
      if (w_coin_entry) begin
        r_sensed <= 1'b0;
      end else if (((r_state == S_COIN) || (r_state == S_SENSE)) && bus.coin_sensed) begin
        r_sensed <= 1'b1;
      end else begin
        r_sensed <= r_sensed;
      end
    end
  end

  // Outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vend_motor  <= 1'b0;
      r_coin_eject  <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
      r_payout_done <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_vend_motor  <= (w_state_nxt == S_VEND);
      r_coin_eject  <= (w_state_nxt == S_COIN);
      r_busy        <= (w_state_nxt != S_IDLE) || w_pend_vld_nxt;
      r_fault       <= (w_state_nxt == S_FAULT);
      r_payout_done <= (w_state_nxt == S_DONE);
      r_overflow    <= w_ovf;
    end
  end

  assign bus.vend_motor  = r_vend_motor;
  assign bus.coin_eject  = r_coin_eject;
  assign bus.busy        = r_busy;
  assign bus.fault       = r_fault;
  assign bus.payout_done = r_payout_done;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_vend_payout_driver.sv
// Self-checking bench for vend_payout_driver: per-cycle vector table for the basic
// payout shapes, plus hand-written sequences for buffering, timeouts and reset.
module tb_vend_payout_driver;
  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int TMO   = 1000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vend_payout_driver_if bus();

  vend_payout_driver #(
    .PULSE_CYCLES  (PULSE),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // expected output packing: {vend_motor, coin_eject, busy, fault, payout_done, overflow}
  typedef struct {
    logic       p;
    logic [1:0] ch;
    logic       vd;
    logic       cs;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [5:0] outs();
    return {bus.vend_motor, bus.coin_eject, bus.busy, bus.fault, bus.payout_done, bus.overflow};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic p, input logic [1:0] ch, input logic vd,
                              input logic cs, input logic [5:0] exp, input int n);
    for (int k = 0; k < n; k++) vecs.push_back('{p, ch, vd, cs, exp});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the actuator side until payout_done or fault: answers the motor at once and
  // senses each coin in its first SENSE cycle, except coin number 'skip'.
  task automatic serve(input int skip, input int max_cyc,
                       output int coins, output bit done, output bit flt);
    bit prev_ce;
    int pw;
    prev_ce = 1'b0;
    pw      = 0;
    coins   = 0;
    done    = 1'b0;
    flt     = 1'b0;
    for (int n = 0; n < max_cyc && !done && !flt; n++) begin
      @(negedge clk);
      bus.product     = 1'b0;
      bus.clear_fault = 1'b0;
      bus.vend_done   = bus.vend_motor;
      bus.coin_sensed = 1'b0;
      if (bus.coin_eject) begin
        if (!prev_ce) begin
          coins++;
          pw = 0;
        end
        pw++;
      end else if (prev_ce) begin
        check("eject_width", pw, PULSE);
        if (coins != skip) bus.coin_sensed = 1'b1;
      end
      prev_ce = bus.coin_eject;
      if (bus.payout_done) done = 1'b1;
      if (bus.fault) flt = 1'b1;
    end
    bus.vend_done   = 1'b0;
    bus.coin_sensed = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  coins;
    bit  done;
    bit  flt;
    int  vcnt;

    bus.product = 1'b0; bus.change = 2'd0; bus.vend_done = 1'b0;
    bus.coin_sensed = 1'b0; bus.clear_fault = 1'b0;

    // change=2, vend_done after 5 motor cycles, sense in each SENSE
    add(1'b1, 2'd2, 1'b0, 1'b0, 6'b000000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b101000, 4);
    add(1'b0, 2'd0, 1'b1, 1'b0, 6'b101000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b011000, 4);
    add(1'b0, 2'd0, 1'b0, 1'b1, 6'b001000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001000, 2);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b011000, 4);
    add(1'b0, 2'd0, 1'b0, 1'b1, 6'b001000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001000, 2);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001010, 1);
    add(1'b0, 2'd3, 1'b0, 1'b0, 6'b000000, 1);
    // change=0: vend only
    add(1'b1, 2'd0, 1'b0, 1'b0, 6'b000000, 1);
    add(1'b0, 2'd3, 1'b0, 1'b0, 6'b001000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b101000, 1);
    add(1'b0, 2'd0, 1'b1, 1'b0, 6'b101000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001010, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b000000, 1);
    // change=1 with an early sense during the eject pulse
    add(1'b1, 2'd1, 1'b0, 1'b0, 6'b000000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001000, 1);
    add(1'b0, 2'd0, 1'b1, 1'b0, 6'b101000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b1, 6'b011000, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b011000, 3);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001000, 3);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b001010, 1);
    add(1'b0, 2'd0, 1'b0, 1'b0, 6'b000000, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 6'b000000);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      bus.product     = vecs[i].p;
      bus.change      = vecs[i].ch;
      bus.vend_done   = vecs[i].vd;
      bus.coin_sensed = vecs[i].cs;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      tick();
    end
    bus.product = 1'b0; bus.vend_done = 1'b0; bus.coin_sensed = 1'b0;

    // three requests while the motor stalls: 2nd buffered, 3rd dropped
    bus.product = 1'b1; bus.change = 2'd1; tick();
    bus.product = 1'b0; tick(); tick();
    bus.product = 1'b1; bus.change = 2'd3; tick();
    bus.change = 2'd2; tick();
    bus.product = 1'b0;
    @(negedge clk);
    check("overflow_pulse", bus.overflow, 1);
    check("overflow_motor_on", bus.vend_motor, 1);
    tick();
    @(negedge clk);
    check("overflow_one_cycle", bus.overflow, 0);
    serve(0, 200, coins, done, flt);
    check("first_req_coins", coins, 1);
    check("first_req_done", done, 1);
    serve(0, 200, coins, done, flt);
    check("buffered_req_coins", coins, 3);
    check("buffered_req_done", done, 1);
    @(negedge clk);
    check("idle_after_buffered", outs(), 6'b000000);

    // motor never reports done: fault after the timeout
    bus.product = 1'b1; bus.change = 2'd0;
    @(negedge clk);
    bus.product = 1'b0;
    vcnt = 0;
    for (int n = 0; n < TMO + 100; n++) begin
      @(negedge clk);
      if (bus.fault) break;
      if (bus.vend_motor) vcnt++;
    end
    check("vend_timeout_cycles", vcnt, TMO);
    check("vend_fault_outputs", outs(), 6'b001100);
    repeat (3) @(negedge clk);
    check("fault_sticky", bus.fault, 1);
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    @(negedge clk);
    check("fault_cleared", outs(), 6'b000000);

    // second coin never sensed: fault, then a request made during fault runs after clear
    bus.product = 1'b1; bus.change = 2'd2;
    serve(2, TMO + 200, coins, done, flt);
    check("nosense_fault", flt, 1);
    check("nosense_no_done", done, 0);
    check("nosense_coins", coins, 2);
    bus.product = 1'b1; bus.change = 2'd3;
    @(negedge clk);
    bus.product = 1'b0;
    @(negedge clk);
    check("fault_intake_busy", outs(), 6'b001100);
    bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.clear_fault = 1'b0;
    check("fault_clear_pending", bus.fault, 0);
    serve(0, 200, coins, done, flt);
    check("after_fault_coins", coins, 3);
    check("after_fault_done", done, 1);

    // asynchronous reset while the eject solenoid is driven
    bus.product = 1'b1; bus.change = 2'd1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      bus.product   = 1'b0;
      bus.vend_done = bus.vend_motor;
      if (bus.coin_eject) break;
    end
    bus.vend_done = 1'b0;
    check("reached_coin", bus.coin_eject, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_eject_drop", bus.coin_eject, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", outs(), 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
